// File: rtl/traffic_pkg.sv
// Shared types for the two-approach intersection controller.
//   lamp_t    : 2-bit lamp drive code (00 green, 01 yellow, 11 red)
//   phase_e   : controller phase, also exported as the debug phase code
//   lamp_a_of / lamp_b_of : lamp decode of a phase for each signal head
package traffic_pkg;

  typedef logic [1:0] lamp_t;

  localparam lamp_t LAMP_GREEN  = 2'b00;
  localparam lamp_t LAMP_YELLOW = 2'b01;
  localparam lamp_t LAMP_RED    = 2'b11;

  typedef enum logic [2:0] {
    A_GRN = 3'd0,
    A_YEL = 3'd1,
    AR_AB = 3'd2,
    B_GRN = 3'd3,
    B_YEL = 3'd4,
    AR_BA = 3'd5
  } phase_e;

  // Lamp A decode; everything outside the A green/yellow phases is red.
  function automatic lamp_t lamp_a_of(input phase_e s);
    case (s)
      A_GRN:   return LAMP_GREEN;
      A_YEL:   return LAMP_YELLOW;
      default: return LAMP_RED;
    endcase
  endfunction

  // Lamp B decode.
  function automatic lamp_t lamp_b_of(input phase_e s);
    case (s)
      B_GRN:   return LAMP_GREEN;
      B_YEL:   return LAMP_YELLOW;
      default: return LAMP_RED;
    endcase
  endfunction

endpackage

// File: rtl/phase_timer.sv
// Saturating phase tick counter.
//   clk, reset_n : clock, async active-low reset
//   i_clr        : clear to zero (wins over i_tick)
//   i_tick       : timebase strobe, advances the count
//   o_cnt        : current count
//   o_e          : count the next tick would produce (saturating cnt+1)
module phase_timer #(
  parameter int unsigned CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_clr,
  input  logic             i_tick,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_e
);

  logic [CNT_W-1:0] r_cnt;

  // Hold at all-ones so a long rest-in-green never wraps.
  assign o_e   = (&r_cnt) ? r_cnt : r_cnt + CNT_W'(1);
  assign o_cnt = r_cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_tick) begin
      r_cnt <= o_e;
    end
  end

endmodule

// File: rtl/traffic_phase_sequencer.sv
// Timed two-approach intersection controller.
//   clk, reset_n         : clock, async active-low reset
//   tick                 : single-cycle timebase strobe
//   T_A, T_B             : approach vehicle sensors (level)
//   ped_req_a, ped_req_b : walk requests parallel to A / B
//   L_A, L_B             : lamp drive codes
//   walk_a, walk_b       : walk indications
//   phase                : current phase code for monitoring
// Outputs are registered from the next-state decode, so they always match
// the registered phase/count and never see a combinational input path.
module traffic_phase_sequencer
  import traffic_pkg::*;
#(
  parameter int unsigned CNT_W     = 6,
  parameter int unsigned GREEN_MIN = 8,
  parameter int unsigned GREEN_MAX = 32,
  parameter int unsigned YELLOW_T  = 3,
  parameter int unsigned ALLRED_T  = 1,
  parameter int unsigned WALK_T    = 6
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       tick,
  input  logic       T_A,
  input  logic       T_B,
  input  logic       ped_req_a,
  input  logic       ped_req_b,
  output logic [1:0] L_A,
  output logic [1:0] L_B,
  output logic       walk_a,
  output logic       walk_b,
  output logic [2:0] phase
);

  localparam logic [CNT_W-1:0] GMIN = CNT_W'(GREEN_MIN);
  localparam logic [CNT_W-1:0] GMAX = CNT_W'(GREEN_MAX);
  localparam logic [CNT_W-1:0] YEL  = CNT_W'(YELLOW_T);
  localparam logic [CNT_W-1:0] ARED = CNT_W'(ALLRED_T);
  localparam logic [CNT_W-1:0] WALK = CNT_W'(WALK_T);

  phase_e           r_state;
  logic             r_ped_pend_a, r_ped_pend_b;
  logic             r_walk_act_a, r_walk_act_b;
  lamp_t            r_l_a, r_l_b;
  logic             r_walk_a, r_walk_b;
  logic [2:0]       r_phase;

  phase_e           w_state_nxt;
  logic             w_chg;
  logic             w_dem_a, w_dem_b;
  logic             w_ped_pend_a_nxt, w_ped_pend_b_nxt;
  logic             w_walk_act_a_nxt, w_walk_act_b_nxt;
  logic [CNT_W-1:0] w_cnt, w_e, w_cnt_nxt;

  phase_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk     (clk),
    .reset_n (reset_n),
    .i_clr   (w_chg),
    .i_tick  (tick),
    .o_cnt   (w_cnt),
    .o_e     (w_e)
  );

  assign w_dem_a = T_A | r_ped_pend_a;
  assign w_dem_b = T_B | r_ped_pend_b;

  // Next phase; timed moves only on tick, illegal codes recover at once.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      A_GRN: if (tick && (w_e >= GMIN) && (!T_A || ((w_e >= GMAX) && w_dem_b)))
               w_state_nxt = A_YEL;
      A_YEL: if (tick && (w_e == YEL))  w_state_nxt = AR_AB;
      AR_AB: if (tick && (w_e == ARED)) w_state_nxt = B_GRN;
      B_GRN: if (tick && (w_e >= GMIN) && (!T_B || ((w_e >= GMAX) && w_dem_a)))
               w_state_nxt = B_YEL;
      B_YEL: if (tick && (w_e == YEL))  w_state_nxt = AR_BA;
      AR_BA: if (tick && (w_e == ARED)) w_state_nxt = A_GRN;
      default: w_state_nxt = AR_BA;
    endcase
  end

  assign w_chg     = (w_state_nxt != r_state);
  assign w_cnt_nxt = w_chg ? '0 : (tick ? w_e : w_cnt);

  // Ped latch: consumed on green entry (a same-cycle request is served too),
  // walk enable dropped on green exit.
  always_comb begin
    w_ped_pend_a_nxt = r_ped_pend_a | ped_req_a;
    w_ped_pend_b_nxt = r_ped_pend_b | ped_req_b;
    w_walk_act_a_nxt = r_walk_act_a;
    w_walk_act_b_nxt = r_walk_act_b;
    if (w_chg && (w_state_nxt == A_GRN)) begin
      w_walk_act_a_nxt = r_ped_pend_a | ped_req_a;
      w_ped_pend_a_nxt = 1'b0;
    end else if (w_chg && (r_state == A_GRN)) begin
      w_walk_act_a_nxt = 1'b0;
    end
    if (w_chg && (w_state_nxt == B_GRN)) begin
      w_walk_act_b_nxt = r_ped_pend_b | ped_req_b;
      w_ped_pend_b_nxt = 1'b0;
    end else if (w_chg && (r_state == B_GRN)) begin
      w_walk_act_b_nxt = 1'b0;
    end
  end

  // State, latches and output registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= AR_BA;
      r_ped_pend_a <= 1'b0;
      r_ped_pend_b <= 1'b0;
      r_walk_act_a <= 1'b0;
      r_walk_act_b <= 1'b0;
      r_l_a        <= LAMP_RED;
      r_l_b        <= LAMP_RED;
      r_walk_a     <= 1'b0;
      r_walk_b     <= 1'b0;
      r_phase      <= 3'(AR_BA);
    end else begin
      r_state      <= w_state_nxt;
      r_ped_pend_a <= w_ped_pend_a_nxt;
      r_ped_pend_b <= w_ped_pend_b_nxt;
      r_walk_act_a <= w_walk_act_a_nxt;
      r_walk_act_b <= w_walk_act_b_nxt;
      r_l_a        <= lamp_a_of(w_state_nxt);
      r_l_b        <= lamp_b_of(w_state_nxt);
      r_walk_a     <= (w_state_nxt == A_GRN) & w_walk_act_a_nxt & (w_cnt_nxt < WALK);
      r_walk_b     <= (w_state_nxt == B_GRN) & w_walk_act_b_nxt & (w_cnt_nxt < WALK);
      r_phase      <= 3'(w_state_nxt);
    end
  end

  assign L_A    = r_l_a;
  assign L_B    = r_l_b;
  assign walk_a = r_walk_a;
  assign walk_b = r_walk_b;
  assign phase  = r_phase;

endmodule

// File: tb/tb_traffic_phase_sequencer.sv
// Testbench for traffic_phase_sequencer: per-tick expected observations
// {phase, L_A, L_B, walk_a, walk_b} are queued ahead of the run and
// popped/compared one tick window at a time.
module tb_traffic_phase_sequencer;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       tick;
  logic       T_A, T_B;
  logic       ped_req_a, ped_req_b;
  logic [1:0] L_A, L_B;
  logic       walk_a, walk_b;
  logic [2:0] phase;

  int n_checks = 0;
  int n_errors = 0;
  logic [8:0] sb_q[$];

  traffic_phase_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .tick      (tick),
    .T_A       (T_A),
    .T_B       (T_B),
    .ped_req_a (ped_req_a),
    .ped_req_b (ped_req_b),
    .L_A       (L_A),
    .L_B       (L_B),
    .walk_a    (walk_a),
    .walk_b    (walk_b),
    .phase     (phase)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Expected observation word built from the lamp table of each phase.
  function automatic logic [8:0] exp_word(input int ph, input bit wa, input bit wb);
    logic [1:0] la, lb;
    case (ph)
      0:       begin la = 2'b00; lb = 2'b11; end
      1:       begin la = 2'b01; lb = 2'b11; end
      3:       begin la = 2'b11; lb = 2'b00; end
      4:       begin la = 2'b11; lb = 2'b01; end
      default: begin la = 2'b11; lb = 2'b11; end
    endcase
    return {3'(ph), la, lb, wa, wb};
  endfunction

  task automatic push(input int ph, input bit wa, input bit wb, input int n);
    for (int i = 0; i < n; i++) sb_q.push_back(exp_word(ph, wa, wb));
  endtask

  // One full default cycle with no walks, starting from A green.
  task automatic push_cycle();
    push(0, 0, 0, 8); push(1, 0, 0, 3); push(2, 0, 0, 1);
    push(3, 0, 0, 8); push(4, 0, 0, 3); push(5, 0, 0, 1);
  endtask

  // One tick window (4 clk). pa_t raises ped_req_a on the tick cycle,
  // pb_gap pulses ped_req_b for one clk between ticks.
  task automatic step(input string tag, input bit pa_t, input bit pb_gap);
    logic [8:0] exp;
    tick = 1'b1;
    ped_req_a = pa_t;
    @(negedge clk);
    tick = 1'b0;
    ped_req_a = 1'b0;
    exp = (sb_q.size() != 0) ? sb_q.pop_front() : 9'h1FF;
    check(tag, 16'({phase, L_A, L_B, walk_a, walk_b}), 16'(exp));
    ped_req_b = pb_gap;
    @(negedge clk);
    ped_req_b = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic run(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0);
  endtask

  task automatic do_reset(input logic ta, input logic tb);
    reset_n = 1'b0;
    tick = 1'b0; ped_req_a = 1'b0; ped_req_b = 1'b0;
    T_A = ta; T_B = tb;
    repeat (2) @(negedge clk);
    check("reset_state", 16'({phase, L_A, L_B, walk_a, walk_b}), 16'(exp_word(5, 0, 0)));
    reset_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic drain(input string tag);
    check(tag, 16'(sb_q.size()), 16'd0);
    sb_q.delete();
  endtask

  initial begin
    // Idle intersection: fixed 24-tick cycle.
    do_reset(1'b0, 1'b0);
    push(5, 0, 0, 0);
    push_cycle(); push_cycle(); push(0, 0, 0, 2);
    run("idle_cycle", 50);
    drain("idle_drain");

    // Both approaches busy: each green maxes out at 32.
    do_reset(1'b1, 1'b1);
    push(0, 0, 0, 32); push(1, 0, 0, 3); push(2, 0, 0, 1);
    push(3, 0, 0, 32); push(4, 0, 0, 3); push(5, 0, 0, 1);
    push(0, 0, 0, 2);
    run("maxout", 74);
    drain("maxout_drain");

    // Only A demand: rest in A green.
    do_reset(1'b1, 1'b0);
    push(0, 0, 0, 210);
    run("rest_a", 210);
    drain("rest_drain");

    // B ped request during A green forces max-out and a B walk.
    do_reset(1'b1, 1'b0);
    push(0, 0, 0, 32); push(1, 0, 0, 3); push(2, 0, 0, 1);
    push(3, 0, 1, 6);  push(3, 0, 0, 2); push(4, 0, 0, 3); push(5, 0, 0, 1);
    push(0, 0, 0, 8);  push(1, 0, 0, 3); push(2, 0, 0, 1);
    push(3, 0, 0, 8);
    for (int k = 1; k <= 68; k++) begin
      step("ped_b", 1'b0, k == 10);
      if (k == 40) T_A = 1'b0;
    end
    drain("ped_b_drain");

    // A request on the very tick that enters A green: one walk only.
    do_reset(1'b0, 1'b0);
    push(0, 1, 0, 6); push(0, 0, 0, 2); push(1, 0, 0, 3); push(2, 0, 0, 1);
    push(3, 0, 0, 8); push(4, 0, 0, 3); push(5, 0, 0, 1);
    push(0, 0, 0, 8); push(1, 0, 0, 1);
    step("ped_a_entry", 1'b1, 1'b0);
    run("ped_a_entry", 32);
    drain("ped_a_drain");

    // Asynchronous reset in the middle of B yellow.
    do_reset(1'b0, 1'b0);
    push(0, 0, 0, 8); push(1, 0, 0, 3); push(2, 0, 0, 1);
    push(3, 0, 0, 8); push(4, 0, 0, 1);
    run("pre_reset", 21);
    #2 reset_n = 1'b0;
    #1;
    check("async_rst_lamps", 16'({L_A, L_B}), 16'h000F);
    check("async_rst_walk",  16'({walk_a, walk_b}), 16'd0);
    check("async_rst_phase", 16'(phase), 16'd5);
    repeat (2) @(negedge clk);
    check("rst_hold", 16'({phase, L_A, L_B, walk_a, walk_b}), 16'(exp_word(5, 0, 0)));
    reset_n = 1'b1;
    push(0, 0, 0, 8); push(1, 0, 0, 1);
    run("post_reset", 9);
    drain("post_reset_drain");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
